// File: rtl/gen_pkg.sv
// Shared definitions for the iterative RV32M divide/remainder unit.
package gen_pkg;
    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;
endpackage

// File: rtl/gen_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and trial-subtract.
module gen_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic [XLEN-1:0] next_quo
);
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    always_comb begin
        w_shift = {rem, quo[XLEN-1]};
        w_diff  = w_shift - {1'b0, divisor};
        // A failed trial leaves a partial remainder below the divisor, so it fits XLEN bits.
        if (!w_diff[XLEN]) begin
            next_rem = w_diff[XLEN-1:0];
            next_quo = {quo[XLEN-2:0], 1'b1};
        end else begin
            next_rem = w_shift[XLEN-1:0];
            next_quo = {quo[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/gen_div.sv
// RV32M DIV/DIVU/REM/REMU unit: one quotient bit per clock, result on the register-file write port.
module gen_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            m_clock,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [1:0]      op,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            rd,
    output logic [4:0]      rd_n,
    output logic [XLEN-1:0] wd
);
    import gen_pkg::*;

    state_e            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    logic [4:0]        r_rdidx;
    logic [XLEN-1:0]   r_rem, r_quo, r_div;
    logic              r_neg_q, r_neg_r;
    logic              r_busy, r_rd;
    logic [4:0]        r_rdn;
    logic [XLEN-1:0]   r_wd;

    logic              w_signed, w_div0, w_ovf, w_special;
    logic [XLEN-1:0]   w_abs_a, w_abs_b;
    logic [XLEN-1:0]   w_step_rem, w_step_quo;
    logic [XLEN-1:0]   w_q_fix, w_r_fix, w_result;

    gen_div_step #(.XLEN(XLEN)) u_step (
        .rem      (r_rem),
        .quo      (r_quo),
        .divisor  (r_div),
        .next_rem (w_step_rem),
        .next_quo (w_step_quo)
    );

    always_comb begin
        w_signed  = (op == OP_DIV) || (op == OP_REM);
        w_div0    = (b == '0);
        w_ovf     = w_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        w_special = w_div0 || w_ovf;
        w_abs_a   = (w_signed && a[XLEN-1]) ? -a : a;
        w_abs_b   = (w_signed && b[XLEN-1]) ? -b : b;
        w_q_fix   = r_neg_q ? -r_quo : r_quo;
        w_r_fix   = r_neg_r ? -r_rem : r_rem;
        w_result  = r_op[1] ? w_r_fix : w_q_fix;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start && !kill) w_next = w_special ? FIX : CALC;
            CALC: begin
                if (kill)
                    w_next = IDLE;
                else if (r_cnt == '1)
                    w_next = FIX;
            end
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge m_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_rd    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_rd    <= (r_state == FIX) && !kill && (r_rdidx != '0);
        end
    end

    always_ff @(posedge m_clock or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_rdidx <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_rdn   <= '0;
            r_wd    <= '0;
        end else begin
            case (r_state)
                IDLE: if (start && !kill) begin
                    r_op    <= op;
                    r_rdidx <= rd_in;
                    r_cnt   <= '0;
                    r_div   <= w_abs_b;
                    // Specials preload the final result with no sign correction left to apply.
                    if (w_div0) begin
                        r_quo   <= '1;
                        r_rem   <= a;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                    end else if (w_ovf) begin
                        r_quo   <= a;
                        r_rem   <= '0;
                        r_neg_q <= 1'b0;
                        r_neg_r <= 1'b0;
                    end else begin
                        r_quo   <= w_abs_a;
                        r_rem   <= '0;
                        r_neg_q <= w_signed && (a[XLEN-1] ^ b[XLEN-1]);
                        r_neg_r <= w_signed && a[XLEN-1];
                    end
                end
                CALC: if (!kill) begin
                    r_rem <= w_step_rem;
                    r_quo <= w_step_quo;
                    r_cnt <= r_cnt + 1'b1;
                end
                FIX: if (!kill) begin
                    r_wd  <= w_result;
                    r_rdn <= r_rdidx;
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign rd   = r_rd;
    assign rd_n = r_rdn;
    assign wd   = r_wd;
endmodule

// File: tb/tb_gen_div.sv
// Randomized self-checking bench for gen_div against an arithmetic reference model.
module tb_gen_div;
    logic        m_clock = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic        kill    = 1'b0;
    logic [1:0]  op      = 2'b00;
    logic [4:0]  rd_in   = 5'd0;
    logic [31:0] a       = '0;
    logic [31:0] b       = '0;
    logic        busy, rd;
    logic [4:0]  rd_n;
    logic [31:0] wd;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] last_wd = '0;

    gen_div #(.XLEN(32), .CNT_W(5)) dut (
        .m_clock (m_clock),
        .rst_n   (rst_n),
        .start   (start),
        .kill    (kill),
        .op      (op),
        .rd_in   (rd_in),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .rd      (rd),
        .rd_n    (rd_n),
        .wd      (wd)
    );

    always #5 m_clock = ~m_clock;

    function automatic bit ref_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        return (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] q, r;
        if (y == 0) begin
            q = 32'hFFFF_FFFF; r = x;
        end else if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0;
        end else if (!o[0]) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
        return o[1] ? r : q;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        else n_pass++;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] rdi);
        int n = 0;
        int gaps = 0;
        logic [31:0] exp = ref_result(o, x, y);
        int lat = ref_special(o, x, y) ? 1 : 33;
        @(negedge m_clock);
        op = o; a = x; b = y; rd_in = rdi; start = 1'b1;
        @(posedge m_clock); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom); rd_in = 5'($urandom);
        while (!rd && n < 40) begin
            if (!busy) gaps++;
            @(posedge m_clock); #1;
            n++;
        end
        chk({name, " latency"}, n, lat);
        chk({name, " busy"}, gaps, 0);
        chk({name, " rd_n"}, {27'd0, rd_n}, {27'd0, rdi});
        chk({name, " wd"}, wd, exp);
        chk({name, " busy@rd"}, {31'd0, busy}, 32'd0);
        @(posedge m_clock); #1;
        chk({name, " rd pulse"}, {31'd0, rd}, 32'd0);
        last_wd = exp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge m_clock);
        @(negedge m_clock); rst_n = 1'b1;
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset rd", {31'd0, rd}, 32'd0);
        chk("reset rd_n", {27'd0, rd_n}, 32'd0);
        chk("reset wd", wd, 32'd0);
        last_wd = '0;
    endtask

    task automatic test_directed();
        run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 5'd5);
        run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 5'd5);
        run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3);
        run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3);
        run_op("rem 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 5'd4);
        run_op("divu 123/0", 2'b01, 32'd123, 32'd0, 5'd6);
        run_op("rem 123/0", 2'b10, 32'd123, 32'd0, 5'd7);
        run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [31:0] x = $urandom;
            logic [31:0] y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = $urandom_range(1, 15);
                3: y = -$urandom_range(1, 15);
                default: ;
            endcase
            run_op("random", 2'($urandom), x, y, 5'($urandom_range(1, 31)));
        end
    endtask

    task automatic test_kill();
        @(negedge m_clock);
        op = 2'b01; a = 32'd1000; b = 32'd3; rd_in = 5'd9; start = 1'b1;
        @(posedge m_clock); #1;
        start = 1'b0;
        repeat (9) @(posedge m_clock);
        #1;
        kill = 1'b1; start = 1'b1; op = 2'b00; a = $urandom; b = 32'd5; rd_in = 5'd12;
        @(posedge m_clock); #1;
        kill = 1'b0; start = 1'b0;
        chk("kill busy", {31'd0, busy}, 32'd0);
        chk("kill rd", {31'd0, rd}, 32'd0);
        chk("kill wd hold", wd, last_wd);
        run_op("after kill", 2'b00, 32'hFFFF_FF9C, 32'd7, 5'd10);
        // kill while the special-case result is pending
        @(negedge m_clock);
        op = 2'b01; a = 32'd55; b = 32'd0; rd_in = 5'd11; start = 1'b1;
        @(posedge m_clock); #1;
        start = 1'b0; kill = 1'b1;
        @(posedge m_clock); #1;
        kill = 1'b0;
        chk("kill fix rd", {31'd0, rd}, 32'd0);
        chk("kill fix busy", {31'd0, busy}, 32'd0);
        chk("kill fix wd", wd, last_wd);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        logic [31:0] e1 = ref_result(2'b01, 32'd1000, 32'd7);
        logic [31:0] e2 = ref_result(2'b10, 32'hFFFF_FC18, 32'd7);
        @(negedge m_clock);
        op = 2'b01; a = 32'd1000; b = 32'd7; rd_in = 5'd1; start = 1'b1;
        @(posedge m_clock); #1;
        op = 2'b10; a = 32'hFFFF_FC18; b = 32'd7; rd_in = 5'd2;
        while (!rd && n < 40) begin @(posedge m_clock); #1; n++; end
        chk("b2b first latency", n, 33);
        chk("b2b first wd", wd, e1);
        @(posedge m_clock); #1;
        start = 1'b0;
        chk("b2b second busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (!rd && n < 40) begin @(posedge m_clock); #1; n++; end
        chk("b2b second latency", n, 33);
        chk("b2b second rd_n", {27'd0, rd_n}, 32'd2);
        chk("b2b second wd", wd, e2);
        last_wd = e2;
    endtask

    task automatic test_x0();
        int rd_seen = 0;
        int busy_bad = 0;
        logic [31:0] exp = ref_result(2'b00, 32'hFFFF_FF9C, 32'd7);
        @(negedge m_clock);
        op = 2'b00; a = 32'hFFFF_FF9C; b = 32'd7; rd_in = 5'd0; start = 1'b1;
        @(posedge m_clock); #1;
        start = 1'b0;
        for (int i = 1; i <= 36; i++) begin
            if (busy !== (i <= 33)) busy_bad++;
            @(posedge m_clock); #1;
            if (rd) rd_seen++;
        end
        chk("x0 rd never", rd_seen, 0);
        chk("x0 busy span", busy_bad, 0);
        chk("x0 wd", wd, exp);
        chk("x0 rd_n", {27'd0, rd_n}, 32'd0);
        last_wd = exp;
    endtask

    task automatic test_reset_mid();
        @(negedge m_clock);
        op = 2'b11; a = $urandom; b = 32'd9; rd_in = 5'd13; start = 1'b1;
        @(posedge m_clock); #1;
        start = 1'b0;
        repeat (5) @(posedge m_clock);
        @(negedge m_clock); rst_n = 1'b0;
        #1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst rd", {31'd0, rd}, 32'd0);
        chk("midrst wd", wd, 32'd0);
        chk("midrst rd_n", {27'd0, rd_n}, 32'd0);
        repeat (2) @(negedge m_clock);
        rst_n = 1'b1;
        last_wd = '0;
        run_op("after midrst", 2'b01, 32'd100, 32'd7, 5'd5);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_kill();
        test_back_to_back();
        test_x0();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
